// File: rtl/instruction_decoder_cnt_if.sv
// Fetch/decode bus between program memory, the decoder and the datapath/sequencer.
interface instruction_decoder_cnt_if #(
  parameter int unsigned CNT_W = 8
);
  logic             stall;
  logic [7:0]       next_instr;
  logic [7:0]       ir;
  logic             jmp;
  logic             jmp_nz;
  logic [3:0]       ir_nibble;
  logic             i_sel;
  logic             x_sel;
  logic             y_sel;
  logic [3:0]       source_sel;
  logic [8:0]       reg_en;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic [7:0]       from_ID;

  // Fetch side: supplies instructions and stall, observes decode.
  modport master (
    output stall, next_instr,
    input  ir, jmp, jmp_nz, ir_nibble, i_sel, x_sel, y_sel, source_sel, reg_en,
    input  cnt, cnt_zero, from_ID
  );

  // Decoder side.
  modport slave (
    input  stall, next_instr,
    output ir, jmp, jmp_nz, ir_nibble, i_sel, x_sel, y_sel, source_sel, reg_en,
    output cnt, cnt_zero, from_ID
  );
endinterface

// File: rtl/instruction_decoder_cnt.sv
// Instruction register + combinational decoder with stall bubbles and a loop counter.
module instruction_decoder_cnt #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned CNT_LOAD = 2 ** (CNT_W - 1),
  parameter bit          CNT_SAT  = 1'b0,
  parameter bit          DBG_SEL  = 1'b0
) (
  input logic                     clk,
  input logic                     reset_n,
  instruction_decoder_cnt_if.slave bus
);

  localparam logic [CNT_W-1:0] LoadVal = CNT_W'(CNT_LOAD);
  localparam logic [7:0]       InstrCntLd  = 8'hCF;
  localparam logic [7:0]       InstrCntDec = 8'hDF;

  logic [7:0]       ir_q, ir_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       is_load, is_move, is_alu, is_jump, is_jnz;
  logic [2:0] load_dst, move_dst, move_src;
  logic [8:0] load_en, move_en;

  // State update; stall freezes ir and blocks counter side effects.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_q    <= 8'h00;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ir_q    <= ir_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: capture fetch, arm valid, execute counter ops of the current ir.
  always_comb begin
    ir_d    = ir_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (!bus.stall) begin
      ir_d    = bus.next_instr;
      valid_d = 1'b1;
      if (valid_q) begin
        if (ir_q == InstrCntLd) begin
          cnt_d = LoadVal;
        end else if (ir_q == InstrCntDec) begin
          if (CNT_SAT && (cnt_q == '0)) cnt_d = '0;
          else                          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    end
  end

  // Instruction class and field extraction plus per-class register enables.
  always_comb begin
    is_load  = ~ir_q[7];
    is_move  = (ir_q[7:6] == 2'b10);
    is_alu   = (ir_q[7:5] == 3'b110);
    is_jump  = (ir_q[7:4] == 4'b1110);
    is_jnz   = (ir_q[7:4] == 4'b1111);
    load_dst = ir_q[6:4];
    move_dst = ir_q[5:3];
    move_src = ir_q[2:0];

    // dm writes also strobe the i-register (address post-modify).
    if (load_dst == 3'd7)      load_en = 9'h0C0;
    else if (load_dst == 3'd4) load_en = 9'h100;
    else                       load_en = 9'h001 << load_dst;

    if ((move_dst == 3'd4) && (move_src == 3'd6)) begin
      move_en = 9'h100;
    end else if ((move_dst == 3'd7) || ((move_src == 3'd7) && (move_dst != 3'd6))) begin
      move_en = (9'h001 << move_dst) | 9'h040;
    end else if (move_dst == 3'd4) begin
      move_en = 9'h100;
    end else begin
      move_en = 9'h001 << move_dst;
    end
  end

  // Output decode: reset-state values until valid, bubble while stalled.
  always_comb begin
    bus.ir_nibble  = ir_q[3:0];
    bus.jmp        = 1'b0;
    bus.jmp_nz     = 1'b0;
    bus.i_sel      = 1'b0;
    bus.x_sel      = 1'b0;
    bus.y_sel      = 1'b0;
    bus.source_sel = 4'd10;
    bus.reg_en     = 9'h1FF;
    if (valid_q) begin
      bus.jmp    = is_jump;
      bus.jmp_nz = is_jnz;
      bus.x_sel  = ir_q[4];
      bus.y_sel  = ir_q[3];
      bus.i_sel  = ~((is_load && (load_dst == 3'd6)) || (is_move && (move_dst == 3'd6)));
      if (is_move) begin
        bus.source_sel = (move_src == move_dst) ? 4'd9 : {1'b0, move_src};
      end else begin
        bus.source_sel = 4'd8;
      end
      if (is_load)      bus.reg_en = load_en;
      else if (is_move) bus.reg_en = move_en;
      else if (is_alu)  bus.reg_en = 9'h010;
      else              bus.reg_en = 9'h000;
      if (bus.stall) begin
        bus.reg_en = 9'h000;
        bus.jmp    = 1'b0;
        bus.jmp_nz = 1'b0;
      end
    end
  end

  // Register/counter observation and debug bus.
  always_comb begin
    bus.ir       = ir_q;
    bus.cnt      = cnt_q;
    bus.cnt_zero = (cnt_q == '0);
    bus.from_ID  = DBG_SEL ? ir_q : 8'(cnt_q);
  end

endmodule

// File: doc/instruction_decoder_cnt.md
# instruction_decoder_cnt

Parametrised successor to the 8-bit microcontroller's instruction decoder. It registers the fetched instruction and decodes it combinationally into datapath controls (register enables, source select, ALU operand selects, jump strobes). It adds a fetch-stall input that inserts bubbles, a parametrised loop counter with load, decrement, wrap or saturate, and zero-flag behaviour, and a selectable debug output. It sits between program memory and the datapath/program-sequencer.

## Interface
- CNT_W, 8, loop-counter width, 1..16
- CNT_LOAD, 2**(CNT_W-1), value loaded by CNTLD; truncated to CNT_W
- CNT_SAT, 0, 0 = decrement wraps 0 -> all-ones; 1 = decrement holds at 0
- DBG_SEL, 0, from_ID source: 0 = counter, 1 = ir
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  1 = hold ir and suppress all side effects this cycle
- next_instr  in  8  instruction from program memory
- ir  out  8  instruction register
- jmp, jmp_nz  out  1 each  unconditional / conditional jump strobes
- ir_nibble  out  4  ir[3:0]
- i_sel, x_sel, y_sel  out  1 each  i-register input select, ALU operand selects
- source_sel  out  4  data-bus source mux select
- reg_en  out  9  bits 0..7 = x0,x1,y0,y1,r,m,i,dm; bit 8 = o_reg
- cnt  out  CNT_W  loop counter
- cnt_zero  out  1  cnt == 0
- from_ID  out  8  debug bus

## Operation
- Instruction classes: LOAD = ir[7]==0, dst ir[6:4]. MOVE = 10, dst ir[5:3], src ir[2:0]. ALU = 110, x ir[4], y ir[3], func ir[2:0]. JUMP = 1110. JNZ = 1111.
- Register codes: 0 x0, 1 x1, 2 y0, 3 y1, 4 o_reg/r, 5 m, 6 i, 7 dm.
- valid: internal flag. Cleared by reset. Set on the first rising edge with reset_n=1 and stall=0. Once set, stays set until reset.
- ir captures next_instr on each edge with stall=0. It holds when stall=1.
- Reset-state outputs, driven while valid=0: jmp 0, jmp_nz 0, i_sel 0, x_sel 0, y_sel 0, source_sel 10, reg_en 9'h1FF.
- Bubble, driven when valid=1 and stall=1: reg_en 0, jmp 0, jmp_nz 0. All other outputs decode normally.
- Normal decode, valid=1 and stall=0:
  - jmp = JUMP; jmp_nz = JNZ.
  - x_sel = ir[4]; y_sel = ir[3].
  - i_sel = 0 for LOAD or MOVE with dst 6; otherwise 1.
  - source_sel: MOVE with src==dst gives 9; other MOVE gives {0,src}; all other classes give 8.
  - reg_en, LOAD: dst 7 sets bits 7 and 6; dst 4 sets bit 8; any other dst sets bit dst.
  - reg_en, MOVE, first matching rule wins:
    - dst 4 and src 6: bit 8.
    - dst 7, or src 7 with dst≠6: bits dst and 6.
    - dst 4: bit 8.
    - otherwise: bit dst.
  - reg_en, ALU: bit 4. JUMP and JNZ: 0.
- ir_nibble = ir[3:0] at all times, including reset.
- Loop counter, evaluated on each edge where valid=1 and stall=0:
  - CNTLD (ALU, x=0, y=1, func 7): cnt <= CNT_LOAD.
  - CNTDEC (ALU, x=1, y=1, func 7): cnt <= cnt-1, modulo 2^CNT_W. If CNT_SAT=1 and cnt==0, cnt holds at 0.
  - Otherwise cnt holds.
- cnt_zero is combinational from cnt.
- from_ID: with DBG_SEL=0, cnt zero-extended (CNT_W<8) or low 8 bits (CNT_W>8). With DBG_SEL=1, ir.

## Timing
- Reset (async, reset_n=0): ir 8'h00, valid 0, cnt 0 (cnt_zero 1). Outputs take the reset-state values immediately, without waiting for a clock.
- Instruction presented on next_instr at edge k appears on ir after edge k. Its decode is valid combinationally through cycle k+1.
- Counter effect of an instruction in ir during cycle n is visible on cnt after edge n+1. Stall or valid=0 during cycle n blocks it.
- stall=1 at an edge: ir and cnt unchanged. The held instruction executes once, in the first cycle where stall=0.
- Reset asserted mid-stream: immediate return to reset-state outputs. First valid decode is the instruction captured on the first un-stalled edge after release.
- stall during the first cycle after reset release: valid stays 0 and outputs stay in reset state.

## Test plan
- Reset then fetch 8'h35 (LOAD x1?): reset outputs are reg_en 1FF, source_sel 10. Decode then gives reg_en 9'h008? No: dst=3, so reg_en 9'h008, i_sel 1, source_sel 8. Next fetch 8'h6A (LOAD i): reg_en 9'h040, i_sel 0.
- MOVE sweep over all 64 dst/src pairs, checked against the rules. Spot checks: 8'hBE (dst 7, src 6) gives reg_en 9'h0C0, source_sel 6. 8'hA6 (dst 4, src 6) gives 9'h100. 8'h9B (dst 3, src 3) gives source_sel 9, reg_en 9'h008.
- CNTLD 8'hCF then three CNTDEC 8'hDF, CNT_W=8: cnt 0x80, 0x7F, 0x7E, 0x7D. from_ID matches. Same sequence with stall=1 on the second CNTDEC: that instruction executes once after stall drops, no double decrement.
- CNT_W=4, CNT_LOAD=1. CNTLD then two CNTDEC: CNT_SAT=0 gives 1, 0, 0xF with cnt_zero pulsing one cycle. CNT_SAT=1 gives 1, 0, 0.
- 8'hE5 gives jmp 1, ir_nibble 5. 8'hF9 gives jmp_nz 1. Both strobes drop to 0 while stall=1.
- Assert reset_n=0 between clock edges during a CNTDEC: cnt goes to 0 and reg_en to 1FF before the next edge. No counter update occurs on that edge.
